// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the decoder_scan block: FSM state encodings and the
// mode-select helper used by the top-level FSM.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIRECT = 2'b01,
    ST_SCAN   = 2'b10
  } state_t;

  // State is a pure function of the current enable and mode inputs.
  function automatic state_t next_state(input logic ena, input logic mode);
    if (!ena) begin
      return ST_IDLE;
    end
    return mode ? ST_SCAN : ST_DIRECT;
  endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Control/data bundle for decoder_scan: select inputs in, decode outputs back.
interface decoder_scan_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned W = 1 << N;

  logic         ena;
  logic         mode;
  logic         load;
  logic [N-1:0] n;
  logic [W-1:0] e;
  logic [N-1:0] idx;
  logic         wrap;

  modport master (output ena, mode, load, n, input e, idx, wrap);
  modport slave  (input ena, mode, load, n, output e, idx, wrap);

endinterface

// File: rtl/decoder_scan_tick_div.sv
// Scan prescaler: counts 0..DIV-1 while run is high and flags the last count.
module tick_div #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic clrn,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Tick is presented in the cycle that holds the last count, so the
  // consumer advances on the same edge that wraps the counter.
  assign tick = run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2**N decoder with direct-select and auto-scan modes,
// optional active-low outputs and a wrap pulse at the end of each scan.
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int unsigned N           = 3,
  parameter int unsigned DIV         = 1,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic           clk,
  input  logic           clrn,
  decoder_scan_if.slave  bus
);

  localparam int unsigned W = 1 << N;
  localparam logic [W-1:0] E_IDLE = ACTIVE_HIGH ? '0 : '1;

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_idx;
  logic [N-1:0] w_idx_nxt;
  logic [W-1:0] r_e;
  logic [W-1:0] w_e_nxt;
  logic [W-1:0] w_dec;
  logic         r_wrap;
  logic         w_wrap_nxt;
  logic         w_entry;
  logic         w_load;
  logic         w_clr;
  logic         w_run;
  logic         w_tick;

  // Entering SCAN or loading restarts the prescaler; otherwise it runs in SCAN.
  always_comb begin
    w_next  = next_state(bus.ena, bus.mode);
    w_entry = (w_next == ST_SCAN) && (r_state != ST_SCAN);
    w_load  = (w_next == ST_SCAN) && bus.load;
    w_clr   = w_entry || w_load;
    w_run   = (w_next == ST_SCAN) && !w_clr;
  end

  tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk  (clk),
    .clrn (clrn),
    .run  (w_run),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_comb begin
    w_idx_nxt  = r_idx;
    w_wrap_nxt = 1'b0;
    case (w_next)
      ST_DIRECT: w_idx_nxt = bus.n;
      ST_SCAN: begin
        if (w_load) begin
          w_idx_nxt = bus.n;
        end else if (w_tick) begin
          w_idx_nxt  = r_idx + 1'b1;
          w_wrap_nxt = (r_idx == '1);
        end
      end
      default: w_idx_nxt = r_idx;
    endcase
  end

  // Generic one-hot decode of the index about to be presented.
  always_comb begin
    w_dec = '0;
    for (int unsigned i = 0; i < W; i++) begin
      w_dec[i] = (w_idx_nxt == N'(i));
    end
    if (w_next == ST_IDLE) begin
      w_e_nxt = E_IDLE;
    end else begin
      w_e_nxt = ACTIVE_HIGH ? w_dec : ~w_dec;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_e     <= E_IDLE;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
      r_e     <= w_e_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.e    = r_e;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: three configurations driven with
// directed vectors; a negedge monitor pops and compares expected outputs.
module tb_decoder_scan;

  logic clk = 1'b0;
  logic clrn0, clrn1, clrn2;

  always #5 clk = ~clk;

  decoder_scan_if #(.N(3)) if0 ();
  decoder_scan_if #(.N(3)) if1 ();
  decoder_scan_if #(.N(4)) if2 ();

  decoder_scan #(.N(3), .DIV(1), .ACTIVE_HIGH(1'b1)) u0 (.clk(clk), .clrn(clrn0), .bus(if0));
  decoder_scan #(.N(3), .DIV(2), .ACTIVE_HIGH(1'b1)) u1 (.clk(clk), .clrn(clrn1), .bus(if1));
  decoder_scan #(.N(4), .DIV(1), .ACTIVE_HIGH(1'b0)) u2 (.clk(clk), .clrn(clrn2), .bus(if2));

  typedef struct {
    int unsigned due;
    int          id;
    logic [15:0] e;
    logic [3:0]  idx;
    logic        wrap;
    string       name;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int id, input logic [15:0] e, input logic [3:0] idx,
                      input logic wrap, input string name, input int unsigned lag = 1);
    exp_t x;
    x.due  = cyc + lag;
    x.id   = id;
    x.e    = e;
    x.idx  = idx;
    x.wrap = wrap;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due in this cycle.
  exp_t        mx;
  logic [15:0] ae;
  logic [3:0]  ai;
  logic        aw;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mx = q.pop_front();
      case (mx.id)
        0:       begin ae = {8'h00, if0.e}; ai = {1'b0, if0.idx}; aw = if0.wrap; end
        1:       begin ae = {8'h00, if1.e}; ai = {1'b0, if1.idx}; aw = if1.wrap; end
        default: begin ae = if2.e;          ai = if2.idx;         aw = if2.wrap; end
      endcase
      n_tests++;
      if (mx.due != cyc || ae !== mx.e || ai !== mx.idx || aw !== mx.wrap) begin
        n_fail++;
        $display("FAIL %s (dut%0d cyc %0d): got e=%h idx=%0d wrap=%b, expected e=%h idx=%0d wrap=%b",
                 mx.name, mx.id, cyc, ae, ai, aw, mx.e, mx.idx, mx.wrap);
      end
    end
  end

  initial begin
    clrn0 = 1'b0; clrn1 = 1'b0; clrn2 = 1'b0;
    if0.ena = 1'b0; if0.mode = 1'b0; if0.load = 1'b0; if0.n = '0;
    if1.ena = 1'b0; if1.mode = 1'b0; if1.load = 1'b0; if1.n = '0;
    if2.ena = 1'b0; if2.mode = 1'b0; if2.load = 1'b0; if2.n = '0;

    // Reset state
    push(0, 16'h0000, 4'd0, 1'b0, "rst_ah");
    push(1, 16'h0000, 4'd0, 1'b0, "rst_ah_div2");
    push(2, 16'hFFFF, 4'd0, 1'b0, "rst_al");
    step();
    step();
    clrn0 = 1'b1; clrn1 = 1'b1; clrn2 = 1'b1;

    // Direct decode sweep
    if0.ena = 1'b1;
    if0.mode = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if0.n = 3'(v);
      push(0, 16'(1 << v), 4'(v), 1'b0, "direct");
      step();
    end

    // Scan with DIV=1: load, tick, load/tick collision, wrap
    if0.mode = 1'b1; if0.load = 1'b1; if0.n = 3'd2;
    push(0, 16'h0004, 4'd2, 1'b0, "scan_load2"); step();
    if0.load = 1'b0;
    push(0, 16'h0008, 4'd3, 1'b0, "scan_adv3"); step();
    if0.load = 1'b1; if0.n = 3'd5;
    push(0, 16'h0020, 4'd5, 1'b0, "load_tick_collide"); step();
    if0.load = 1'b0;
    push(0, 16'h0040, 4'd6, 1'b0, "scan_adv6"); step();
    push(0, 16'h0080, 4'd7, 1'b0, "scan_adv7"); step();
    push(0, 16'h0001, 4'd0, 1'b1, "scan_wrap"); step();
    push(0, 16'h0002, 4'd1, 1'b0, "scan_post_wrap"); step();
    step();

    // Async reset pulse between edges, then restart from 0
    clrn0 = 1'b0;
    #2;
    clrn0 = 1'b1;
    push(0, 16'h0000, 4'd0, 1'b0, "async_rst", 0);
    push(0, 16'h0001, 4'd0, 1'b0, "restart0"); step();
    push(0, 16'h0002, 4'd1, 1'b0, "restart1"); step();
    if0.ena = 1'b0;

    // Scan with DIV=2 and wrap
    if1.ena = 1'b1; if1.mode = 1'b1; if1.load = 1'b1; if1.n = 3'd6;
    push(1, 16'h0040, 4'd6, 1'b0, "div2_load6"); step();
    if1.load = 1'b0;
    push(1, 16'h0040, 4'd6, 1'b0, "div2_hold6"); step();
    push(1, 16'h0080, 4'd7, 1'b0, "div2_adv7"); step();
    push(1, 16'h0080, 4'd7, 1'b0, "div2_hold7"); step();
    push(1, 16'h0001, 4'd0, 1'b1, "div2_wrap"); step();
    push(1, 16'h0001, 4'd0, 1'b0, "div2_hold0"); step();

    // Enable gating mid-scan at idx=4
    if1.load = 1'b1; if1.n = 3'd4;
    push(1, 16'h0010, 4'd4, 1'b0, "gate_load4"); step();
    if1.load = 1'b0; if1.ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(1, 16'h0000, 4'd4, 1'b0, "gated"); step();
    end
    if1.ena = 1'b1;
    push(1, 16'h0010, 4'd4, 1'b0, "resume_entry"); step();
    push(1, 16'h0010, 4'd4, 1'b0, "resume_hold"); step();
    push(1, 16'h0020, 4'd5, 1'b0, "resume_adv5"); step();
    if1.ena = 1'b0;

    // Active-low, N=4
    if2.ena = 1'b1; if2.mode = 1'b0; if2.n = 4'd9;
    push(2, 16'hFDFF, 4'd9, 1'b0, "al_n9"); step();
    if2.n = 4'd0;
    push(2, 16'hFFFE, 4'd0, 1'b0, "al_n0"); step();
    if2.n = 4'd15;
    push(2, 16'h7FFF, 4'd15, 1'b0, "al_n15"); step();
    if2.ena = 1'b0;
    push(2, 16'hFFFF, 4'd15, 1'b0, "al_idle"); step();
    if2.ena = 1'b1; if2.mode = 1'b1;
    push(2, 16'h7FFF, 4'd15, 1'b0, "al_scan_entry"); step();
    push(2, 16'hFFFE, 4'd0, 1'b1, "al_scan_wrap"); step();
    if2.ena = 1'b0;

    step();
    step();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
